// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the Booth multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int N_DEF = 8;

    localparam logic [1:0] BOOTH_NOP = 2'b00;
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    // Map the Booth pair {Q[0], Q_1} to the accumulator operation.
    function automatic logic [1:0] booth_op(input logic [1:0] bits);
        case (bits)
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/module_booth_dp.sv
// rtl/module_booth_dp.sv - Booth datapath: M/ACC/Q/Q_1 registers, add/sub and shifter
module module_booth_dp
    import mult_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic           step_i,
    input  logic           last_i,
    input  logic [1:0]     op_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [1:0]     booth_bits_o,
    output logic [2*N-1:0] product_o
);

    logic [N:0]     m_q;
    logic [N:0]     acc_q;
    logic [N-1:0]   q_q;
    logic           q1_q;
    logic [2*N-1:0] prod_q;

    logic [N:0]     sum;
    logic [N:0]     acc_d;
    logic [N-1:0]   q_d;
    logic           q1_d;

    // One Booth step: add/subtract M, then arithmetic shift of {ACC, Q, Q_1}.
    always_comb begin
        sum = acc_q;
        case (op_i)
            BOOTH_ADD: sum = acc_q + m_q;
            BOOTH_SUB: sum = acc_q - m_q;
            default:   sum = acc_q;
        endcase
        acc_d = {sum[N], sum[N:1]};
        q_d   = {sum[0], q_q[N-1:1]};
        q1_d  = q_q[0];
    end

    // Operand load on accept, step during CALC; product captured on the final step
    // so it stays stable in DONE and holds its value through the next operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q    <= '0;
            acc_q  <= '0;
            q_q    <= '0;
            q1_q   <= 1'b0;
            prod_q <= '0;
        end else if (load_i) begin
            m_q   <= {a_i[N-1], a_i};
            acc_q <= '0;
            q_q   <= b_i;
            q1_q  <= 1'b0;
        end else if (step_i) begin
            acc_q <= acc_d;
            q_q   <= q_d;
            q1_q  <= q1_d;
            if (last_i) begin
                prod_q <= {acc_d[N-1:0], q_d};
            end
        end
    end

    assign booth_bits_o = {q_q[0], q1_q};
    assign product_o    = prod_q;

endmodule

// File: rtl/module_booth_mult.sv
// rtl/module_booth_mult.sv - sequential radix-2 Booth multiplier with valid/ready handshakes
module module_booth_mult
    import mult_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int            CW       = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N);

    mult_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load;
    logic          step;
    logic          last;
    logic [1:0]    booth_bits;
    logic [1:0]    op;

    // State and iteration counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and datapath controls; the step taken with CNT == 1 is the last.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = CALC;
                end
            end
            CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign op        = booth_op(booth_bits);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    module_booth_dp #(
        .N(N)
    ) u_dp (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .step_i      (step),
        .last_i      (last),
        .op_i        (op),
        .a_i         (a),
        .b_i         (b),
        .booth_bits_o(booth_bits),
        .product_o   (product)
    );

endmodule

// File: tb/tb_module_booth_mult.sv
// tb/tb_module_booth_mult.sv - directed self-checking bench for module_booth_mult
module tb_module_booth_mult;

    localparam int N = 8;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           busy;

    int checks;
    int errors;

    module_booth_mult #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full operation with out_ready held high; checks accept, latency and product.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic [15:0] exp, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_product"}, 32'(product), 32'(exp));
        @(posedge clk); #1;
        chk({tag, "_idle_after"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        logic [7:0]  ra, rb;
        int          p;
        logic [15:0] held;

        checks = 0; errors = 0;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        #12;
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_product", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        do_op(8'd7,    8'hFD, 16'hFFEB, "7x-3");
        do_op(8'h80,   8'h80, 16'h4000, "-128x-128");
        do_op(8'h80,   8'h7F, 16'hC080, "-128x127");
        do_op(8'h00,   8'h55, 16'h0000, "0x55");
        do_op(8'h01,   8'hFF, 16'hFFFF, "1x-1");

        // Backpressure: hold DONE while new operands are offered.
        out_ready = 1'b0;
        a = 8'd12; b = 8'd10; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 8'hFE; b = 8'd9;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
        chk("bp_done", 32'(out_valid), 32'd1);
        chk("bp_product", 32'(product), 32'h0078);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold_prod%0d", i), 32'(product), 32'h0078);
            chk($sformatf("bp_hold_ready%0d", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", 32'(in_ready), 32'd1);
        chk("bp_release_prod", 32'(product), 32'h0078);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_product", 32'(product), 32'hFFEE);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of CALC.
        a = 8'd100; b = 8'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        chk("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        do_op(8'd5, 8'd6, 16'h001E, "5x6");

        // Random signed pairs with idle gaps; reference is the signed product.
        for (int k = 0; k < 16; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            p = int'($signed(ra)) * int'($signed(rb));
            held = p[15:0];
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            do_op(ra, rb, held, $sformatf("rand%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
